// File: rtl/id_ex_pipe_ctrl.sv
// id_ex_pipe_ctrl: ID/EX pipeline register with stall/flush sequencing and operand forwarding; STALL_COUNTER_EN enables the stall-cycle counter
module id_ex_pipe_ctrl #(
    parameter int DATA_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              w_stall,
    input  logic              w_flush,
    input  logic              w_dvalid,
    input  logic              w_dalu_op,
    input  logic              w_dimm_op,
    input  logic              w_dmem_op,
    input  logic              w_dwrite_op,
    input  logic [4:0]        w_drs_addr_5,
    input  logic [4:0]        w_drt_addr_5,
    input  logic [4:0]        w_drd_addr_5,
    input  logic [DATA_W-1:0] w_drs_data,
    input  logic [DATA_W-1:0] w_drt_data,
    input  logic [DATA_W-1:0] w_dimm_data,
    input  logic              w_me_rs_bypass,
    input  logic              w_me_rt_bypass,
    input  logic              w_we_rs_bypass,
    input  logic              w_we_rt_bypass,
    input  logic [DATA_W-1:0] w_mem_fwd_data,
    input  logic [DATA_W-1:0] w_wb_fwd_data,
    output logic              w_evalid,
    output logic              w_ealu_op,
    output logic              w_eimm_op,
    output logic              w_emem_op,
    output logic              w_ewrite_op,
    output logic [4:0]        w_ers_addr_5,
    output logic [4:0]        w_ert_addr_5,
    output logic [4:0]        w_erd_addr_5,
    output logic [DATA_W-1:0] w_ers_data,
    output logic [DATA_W-1:0] w_ert_data,
    output logic [DATA_W-1:0] w_eimm_data,
    output logic              w_fetch_hold,
    output logic [15:0]       w_stall_count_16
);
    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] STALL      = 2'd1;
    localparam logic [1:0] FLUSH      = 2'd2;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    logic [1:0]        state;
    logic [3:0]        flush_cnt;
    logic              in_flush;
    logic              bubble;
    logic [DATA_W-1:0] rs_sel;
    logic [DATA_W-1:0] rt_sel;

    assign in_flush     = state == FLUSH;
    assign w_fetch_hold = w_stall & ~w_flush & ~in_flush;
    assign bubble       = w_flush | in_flush | w_stall;

    // Forwarding mux: execute-result beats writeback beats register file
    always_comb begin
        rs_sel = w_me_rs_bypass ? w_mem_fwd_data : w_we_rs_bypass ? w_wb_fwd_data : w_drs_data;
        rt_sel = w_me_rt_bypass ? w_mem_fwd_data : w_we_rt_bypass ? w_wb_fwd_data : w_drt_data;
    end

    // Sequencer: flush window occupies exactly FLUSH_CYCLES bubbles, then back to RUN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else if (w_flush) begin
            state     <= (FLUSH_CYCLES == 1) ? RUN : FLUSH;
            flush_cnt <= FLUSH_LOAD;
        end else if (in_flush) begin
            state     <= (flush_cnt <= 4'd1) ? RUN : FLUSH;
            flush_cnt <= flush_cnt - 4'd1;
        end else begin
            state     <= w_stall ? STALL : RUN;
        end
    end

    // Execute-stage register: bubble on any stall/flush, otherwise capture decode fields
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n || bubble) begin
            {w_evalid, w_ealu_op, w_eimm_op, w_emem_op, w_ewrite_op} <= '0;
            {w_ers_addr_5, w_ert_addr_5, w_erd_addr_5}                <= '0;
            {w_ers_data, w_ert_data, w_eimm_data}                     <= '0;
        end else begin
            {w_evalid, w_ealu_op, w_eimm_op, w_emem_op, w_ewrite_op} <=
                {w_dvalid, w_dalu_op, w_dimm_op, w_dmem_op, w_dwrite_op};
            {w_ers_addr_5, w_ert_addr_5, w_erd_addr_5} <= {w_drs_addr_5, w_drt_addr_5, w_drd_addr_5};
            {w_ers_data, w_ert_data, w_eimm_data}      <= {rs_sel, rt_sel, w_dimm_data};
        end
    end

`ifdef STALL_COUNTER_EN
    logic [15:0] stall_count;
    // Count stall bubbles only, saturating
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_count <= '0;
        else if (w_fetch_hold && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
    assign w_stall_count_16 = stall_count;
`else
    assign w_stall_count_16 = '0;
`endif
endmodule

// File: tb/tb_id_ex_pipe_ctrl.sv
// tb_id_ex_pipe_ctrl: directed and randomized checks of id_ex_pipe_ctrl against a bubble-window model
module tb_id_ex_pipe_ctrl;
    localparam int W  = 32;
    localparam int FC = 2;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         stall, flush, dvalid, dalu, dimm, dmem, dwrite;
    logic [4:0]   rs_a, rt_a, rd_a;
    logic [W-1:0] rs_d, rt_d, imm_d, mem_fwd, wb_fwd;
    logic         me_rs, me_rt, we_rs, we_rt;
    logic         evalid, ealu, eimm, emem, ewrite, hold;
    logic [4:0]   ers_a, ert_a, erd_a;
    logic [W-1:0] ers_d, ert_d, eimm_d;
    logic [15:0]  cnt;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           left = 0;
    logic [127:0] exp_e = '0;
    logic [15:0]  exp_cnt = '0;
    logic [15:0]  base_cnt;

    id_ex_pipe_ctrl #(.DATA_W(W), .FLUSH_CYCLES(FC)) dut (
        .clock(clock), .reset_n(reset_n), .w_stall(stall), .w_flush(flush),
        .w_dvalid(dvalid), .w_dalu_op(dalu), .w_dimm_op(dimm), .w_dmem_op(dmem), .w_dwrite_op(dwrite),
        .w_drs_addr_5(rs_a), .w_drt_addr_5(rt_a), .w_drd_addr_5(rd_a),
        .w_drs_data(rs_d), .w_drt_data(rt_d), .w_dimm_data(imm_d),
        .w_me_rs_bypass(me_rs), .w_me_rt_bypass(me_rt), .w_we_rs_bypass(we_rs), .w_we_rt_bypass(we_rt),
        .w_mem_fwd_data(mem_fwd), .w_wb_fwd_data(wb_fwd),
        .w_evalid(evalid), .w_ealu_op(ealu), .w_eimm_op(eimm), .w_emem_op(emem), .w_ewrite_op(ewrite),
        .w_ers_addr_5(ers_a), .w_ert_addr_5(ert_a), .w_erd_addr_5(erd_a),
        .w_ers_data(ers_d), .w_ert_data(ert_d), .w_eimm_data(eimm_d),
        .w_fetch_hold(hold), .w_stall_count_16(cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] dut_e();
        return {12'b0, evalid, ealu, eimm, emem, ewrite, ers_a, ert_a, erd_a, ers_d, ert_d, eimm_d};
    endfunction

    // Reference: a flush opens a window of FC forced bubbles; stalls bubble only outside it
    task automatic model_edge();
        logic [W-1:0] a, b;
        if (flush) begin
            exp_e = '0;
            left  = FC - 1;
        end else if (left > 0) begin
            exp_e = '0;
            left--;
        end else if (stall) begin
            exp_e = '0;
`ifdef STALL_COUNTER_EN
            if (exp_cnt != 16'hFFFF) exp_cnt++;
`endif
        end else begin
            a = rs_d;
            if (we_rs) a = wb_fwd;
            if (me_rs) a = mem_fwd;
            b = rt_d;
            if (we_rt) b = wb_fwd;
            if (me_rt) b = mem_fwd;
            exp_e = {12'b0, dvalid, dalu, dimm, dmem, dwrite, rs_a, rt_a, rd_a, a, b, imm_d};
        end
    endtask

    task automatic model_reset();
        left    = 0;
        exp_e   = '0;
        exp_cnt = '0;
    endtask

    task automatic cycle();
        @(negedge clock);
        chk("fetch_hold", 128'(hold), 128'(left == 0 && stall && !flush));
        @(posedge clock);
        model_edge();
        #1;
        chk("exec", dut_e(), exp_e);
        chk("stall_count", 128'(cnt), 128'(exp_cnt));
    endtask

    task automatic idle();
        {stall, flush, dvalid, dalu, dimm, dmem, dwrite} = '0;
        {rs_a, rt_a, rd_a} = '0;
        {rs_d, rt_d, imm_d, mem_fwd, wb_fwd} = '0;
        {me_rs, me_rt, we_rs, we_rt} = '0;
    endtask

    task automatic rand_decode();
        {dvalid, dalu, dimm, dmem, dwrite} = 5'($urandom);
        {rs_a, rt_a, rd_a} = 15'($urandom);
        rs_d = $urandom; rt_d = $urandom; imm_d = $urandom;
        mem_fwd = $urandom; wb_fwd = $urandom;
        {me_rs, me_rt, we_rs, we_rt} = 4'($urandom);
    endtask

    initial begin
        idle();
        stall = 1'b1;
        #3;
        chk("reset_exec", dut_e(), '0);
        chk("reset_count", 128'(cnt), '0);
        chk("reset_hold", 128'(hold), 128'(1));
        @(negedge clock);
        reset_n = 1'b1;
        idle();
        model_reset();

        dvalid = 1; dalu = 1; rs_d = 5;
        cycle();
        chk("basic_evalid", 128'(evalid), 128'(1));
        chk("basic_rs", 128'(ers_d), 128'(5));

        me_rs = 1; we_rs = 1; mem_fwd = 'hAA; wb_fwd = 'hBB;
        cycle();
        chk("me_wins", 128'(ers_d), 128'('hAA));
        me_rs = 0;
        cycle();
        chk("we_only", 128'(ers_d), 128'('hBB));

        base_cnt = exp_cnt;
        rand_decode();
        dvalid = 1;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_bubble", 128'(evalid), '0);
        end
        stall = 0;
        cycle();
        chk("stall_release", 128'(evalid), 128'(1));
`ifdef STALL_COUNTER_EN
        chk("stall_cnt3", 128'(cnt), 128'(base_cnt + 16'd3));
`else
        chk("stall_cnt0", 128'(cnt), '0);
`endif

        base_cnt = exp_cnt;
        flush = 1; stall = 1;
        cycle();
        flush = 0; stall = 0;
        cycle();
        chk("flush_bubble2", 128'(evalid), '0);
        cycle();
        chk("flush_resume", 128'(evalid), 128'(1));
        chk("flush_nocount", 128'(cnt), 128'(base_cnt));

        flush = 1;
        cycle();
        cycle();
        flush = 0;
        cycle();
        chk("reflush_bubble3", 128'(evalid), '0);
        cycle();
        chk("reflush_resume", 128'(evalid), 128'(1));

        flush = 1;
        cycle();
        flush = 0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_exec", dut_e(), '0);
        chk("async_reset_count", 128'(cnt), '0);
        reset_n = 1'b1;
        rand_decode();
        dvalid = 1;
        cycle();
        chk("post_reset_capture", 128'(evalid), 128'(1));

        for (int i = 0; i < 3000; i++) begin
            rand_decode();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe_ctrl.md
ID_EX_PIPE_CTRL -- requirements
Module: id_ex_pipe_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of operands and immediates.
REQ-002 Parameter FLUSH_CYCLES, default 2, number of bubble cycles inserted per flush; legal range 1..15.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 w_stall  input  1  load-use stall request from hazard detection.
REQ-006 w_flush  input  1  branch/jump squash request.
REQ-007 w_dvalid, w_dalu_op, w_dimm_op, w_dmem_op, w_dwrite_op  input  1 each  decode-stage control bits.
REQ-008 w_drs_addr_5, w_drt_addr_5, w_drd_addr_5  input  5 each  decode-stage register addresses.
REQ-009 w_drs_data, w_drt_data, w_dimm_data  input  DATA_W each  register-file read data and sign-extended immediate.
REQ-010 w_me_rs_bypass, w_me_rt_bypass, w_we_rs_bypass, w_we_rt_bypass  input  1 each  forwarding selects.
REQ-011 w_mem_fwd_data, w_wb_fwd_data  input  DATA_W each  execute-result and writeback forwarding data.
REQ-012 w_evalid, w_ealu_op, w_eimm_op, w_emem_op, w_ewrite_op  output  1 each  registered execute-stage control.
REQ-013 w_ers_addr_5, w_ert_addr_5, w_erd_addr_5  output  5 each  registered execute-stage addresses.
REQ-014 w_ers_data, w_ert_data, w_eimm_data  output  DATA_W each  registered forwarded operands and immediate.
REQ-015 w_fetch_hold  output  1  combinational; freezes PC and IF/ID register when high.
REQ-016 w_stall_count_16  output  16  stall-cycle counter (see Configuration).

Function
REQ-017 FSM states RUN, STALL, FLUSH; w_flush has priority over w_stall in every state.
REQ-018 RUN, no request: capture all decode fields into execute outputs; w_evalid = w_dvalid.
REQ-019 Operand select per edge: w_me_*_bypass -> w_mem_fwd_data; else w_we_*_bypass -> w_wb_fwd_data; else register-file data; rs and rt independent.
REQ-020 Both me and we selects high on same operand: me wins.
REQ-021 w_stall high in RUN or STALL (no flush): next edge loads bubble (w_evalid and all four control outputs 0, addresses 0, data 0); state STALL.
REQ-022 w_fetch_hold = w_stall & ~w_flush while in RUN or STALL; 0 in FLUSH.
REQ-023 STALL with w_stall low: capture decode fields as REQ-018; state RUN; instruction enters execute exactly one cycle after stall drops.
REQ-024 w_flush high in any state: next edge loads bubble, loads internal flush counter with FLUSH_CYCLES-1, state FLUSH.
REQ-025 FLUSH: bubble loaded each edge; counter decrements; at counter 0 state RUN; FLUSH_CYCLES=1 returns to RUN after one bubble.
REQ-026 w_flush re-asserted during FLUSH reloads counter (FLUSH_CYCLES-1) and restarts the bubble window.
REQ-027 Decode inputs and bypass selects are ignored while FLUSH or stalling.
REQ-028 Capture latency: one cycle, decode inputs to execute outputs.

Reset
REQ-029 reset_n low: immediately state RUN, flush counter 0, all execute outputs 0, w_stall_count_16 0.
REQ-030 Reset asserted mid-STALL or mid-FLUSH abandons the operation; first post-reset edge behaves as RUN.
REQ-031 w_fetch_hold during reset = w_stall & ~w_flush (state RUN).

Configuration
REQ-032 Macro STALL_COUNTER_EN defined: w_stall_count_16 increments by 1 on each edge where a stall bubble (REQ-021) is loaded, saturating at 16'hFFFF; flush bubbles not counted.
REQ-033 STALL_COUNTER_EN undefined: no counter register; w_stall_count_16 tied to 0.

Verification
REQ-034 Reset, then w_dvalid=1, w_dalu_op=1, w_drs_data=5, no bypass -> next cycle w_evalid=1, w_ers_data=5.
REQ-035 w_me_rs_bypass=1, w_we_rs_bypass=1, w_mem_fwd_data=0xAA, w_wb_fwd_data=0xBB -> w_ers_data=0xAA; only we set -> 0xBB.
REQ-036 w_stall high 3 cycles -> w_fetch_hold high 3 cycles, 3 bubbles (w_evalid=0), held instruction appears cycle 4; count=3 with STALL_COUNTER_EN, 0 without.
REQ-037 w_flush and w_stall together for 1 cycle, FLUSH_CYCLES=2 -> w_fetch_hold=0, exactly 2 bubbles, then RUN capture; count unchanged.
REQ-038 w_flush re-pulsed in second FLUSH cycle -> bubble window extends to 3 cycles total.
REQ-039 reset_n pulsed low mid-FLUSH -> outputs 0 asynchronously, next edge captures decode inputs normally.
